seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seven_segment_capture.sv | 148 ++++++++++++++
 tb/tb_seven_segment_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Reconstructs a 32-bit hex value by observing a multiplexed seven-segment display bus.
// Optional saturating error counter port enabled by SEVEN_SEGMENT_CAPTURE_ERRCNT_EN.
module seven_segment_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  cat,
    input  logic [7:0]  an,
    output logic [31:0] val,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        decode_err
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES);
    localparam logic [15:0] CNT_FIRE = 16'(STABLE_CYCLES - 1);

    logic [6:0]  r_cat_meta, r_cat_sync;
    logic [7:0]  r_an_meta, r_an_sync;
    logic [14:0] r_prev;
    logic [15:0] r_cnt;
    logic [7:0]  r_seen;
    logic [31:0] r_val;
    logic [7:0]  r_digit_valid;
    logic        r_frame_done;
    logic        r_decode_err;

    logic [7:0]  w_dmask;
    logic        w_onehot;
    logic        w_same;
    logic        w_capture;
    logic [7:0]  w_cap_mask;
    logic [6:0]  w_cap_pat;
    logic [7:0]  w_seen_next;
    logic        w_known;
    logic [3:0]  w_nibble;

    // The capture acts on r_prev: it holds the sample that completed the stable run,
    // even if the live sample has already moved on by the time the counter fires.
    always_comb begin
        w_dmask     = ~r_an_sync;
        w_onehot    = (w_dmask != 8'h00) && ((w_dmask & (w_dmask - 8'd1)) == 8'h00);
        w_same      = ({r_cat_sync, r_an_sync} == r_prev);
        w_capture   = (r_cnt == CNT_FIRE);
        w_cap_mask  = ~r_prev[7:0];
        w_cap_pat   = ~r_prev[14:8];
        w_seen_next = r_seen | w_cap_mask;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_known  = 1'b1;
        w_nibble = 4'h0;
        case (w_cap_pat)
            7'h3F: w_nibble = 4'h0;
            7'h06: w_nibble = 4'h1;
            7'h5B: w_nibble = 4'h2;
            7'h4F: w_nibble = 4'h3;
            7'h66: w_nibble = 4'h4;
            7'h6D: w_nibble = 4'h5;
            7'h7D: w_nibble = 4'h6;
            7'h07: w_nibble = 4'h7;
            7'h7F: w_nibble = 4'h8;
            7'h6F: w_nibble = 4'h9;
            7'h77: w_nibble = 4'hA;
            7'h7C: w_nibble = 4'hB;
            7'h39: w_nibble = 4'hC;
            7'h5E: w_nibble = 4'hD;
            7'h79: w_nibble = 4'hE;
            7'h71: w_nibble = 4'hF;
            default: w_known = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cat_meta    <= '1;
            r_cat_sync    <= '1;
            r_an_meta     <= '1;
            r_an_sync     <= '1;
            r_prev        <= '1;
            r_cnt         <= '0;
            r_seen        <= '0;
            r_val         <= '0;
            r_digit_valid <= '0;
            r_frame_done  <= 1'b0;
            r_decode_err  <= 1'b0;
        end else begin
            r_cat_meta <= cat;
            r_cat_sync <= r_cat_meta;
            r_an_meta  <= an;
            r_an_sync  <= r_an_meta;
            r_prev     <= {r_cat_sync, r_an_sync};

            if (!w_same || !w_onehot) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 16'd1;
            end

            r_frame_done <= 1'b0;
            if (w_capture) begin
                if (w_known) begin
                    for (int k = 0; k < 8; k++) begin
                        if (w_cap_mask[k]) begin
                            r_val[4*k +: 4] <= w_nibble;
                        end
                    end
                    r_digit_valid <= r_digit_valid | w_cap_mask;
                    if (w_seen_next == 8'hFF) begin
                        r_frame_done <= 1'b1;
                        r_seen       <= '0;
                    end else begin
                        r_seen <= w_seen_next;
                    end
                end else begin
                    r_decode_err <= 1'b1;
                end
            end
        end
    end

`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_capture && !w_known && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign val         = r_val;
    assign digit_valid = r_digit_valid;
    assign frame_done  = r_frame_done;
    assign decode_err  = r_decode_err;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture: a per-cycle behavioural model plus
// directed scenarios with literal expectations (STABLE_CYCLES = 4).
module tb_seven_segment_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  cat = 7'h7F;
    logic [7:0]  an  = 8'hFF;
    logic [31:0] val;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        decode_err;
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int errors = 0;
    int fd_pulses = 0;

    seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .cat         (cat),
        .an          (an),
        .val         (val),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .decode_err  (decode_err)
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: S is the input as seen two edges late; a digit is taken when S has been
    // identical for exactly STABLE cycles with a single anode active, and lands two edges later.
    logic [31:0] m_val;
    logic [7:0]  m_dv, m_seen, m_errcnt;
    logic        m_fd, m_err;
    logic [14:0] m_a, m_s, pc0, pc1;
    bit          pv0, pv1;
    int          m_run;

    task automatic model_apply(input logic [14:0] s);
        logic [7:0] d;
        logic [6:0] p;
        int idx;
        int k;
        d = ~s[7:0];
        p = ~s[14:8];
        idx = -1;
        k = 0;
        for (int i = 0; i < 16; i++) if (seg_of(i) == p) idx = i;
        if (idx < 0) begin
            m_err = 1'b1;
            if (m_errcnt != 8'hFF) m_errcnt++;
        end else begin
            for (int i = 0; i < 8; i++) if (d[i]) k = i;
            m_val[4*k +: 4] = 4'(idx);
            m_dv[k]   = 1'b1;
            m_seen[k] = 1'b1;
            if (m_seen == 8'hFF) begin
                m_fd   = 1'b1;
                m_seen = 8'h00;
            end
        end
    endtask

    task automatic model_step();
        logic [14:0] s_new;
        if (rst) begin
            m_val = '0; m_dv = '0; m_seen = '0; m_errcnt = '0;
            m_fd = 1'b0; m_err = 1'b0;
            m_a = '1; m_s = '1; m_run = 1;
            pv0 = 1'b0; pv1 = 1'b0; pc0 = '1; pc1 = '1;
        end else begin
            m_fd = 1'b0;
            if (pv1) model_apply(pc1);
            pv1 = pv0;
            pc1 = pc0;
            s_new = m_a;
            m_a = {cat, an};
            if (s_new == m_s) begin
                if (m_run < 100000) m_run++;
            end else begin
                m_run = 1;
            end
            m_s = s_new;
            pv0 = (m_run == STABLE) && ($countones(~m_s[7:0]) == 1);
            pc0 = m_s;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("val", val, m_val);
            check("digit_valid", {24'h0, digit_valid}, {24'h0, m_dv});
            check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
            check("decode_err", {31'h0, decode_err}, {31'h0, m_err});
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
            check("err_count", {24'h0, err_count}, {24'h0, m_errcnt});
`endif
            if (frame_done === 1'b1) fd_pulses++;
        end
    end

    task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
        an  = a;
        cat = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] v, input int dwell, input logic [7:0] skip);
        for (int k = 0; k < 8; k++) begin
            if (!skip[k]) hold(~(8'h01 << k), ~seg_of(int'(v[4*k +: 4])), dwell);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int base;
    int lat;

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset val", val, 32'h0);
        check("reset digit_valid", {24'h0, digit_valid}, 32'h0);
        check("reset frame_done", {31'h0, frame_done}, 32'h0);
        check("reset decode_err", {31'h0, decode_err}, 32'h0);

        // Full scan, one frame.
        base = fd_pulses;
        scan(32'h12345678, 100, 8'h00);
        check("scan val", val, 32'h12345678);
        check("scan digit_valid", {24'h0, digit_valid}, 32'hFF);
        check("scan frame pulses", base + 1, fd_pulses);

        // Short-lived "1" must not be captured; the following "2" is.
        hold(8'hFE, ~7'h06, 3);
        hold(8'hFE, ~7'h5B, 20);
        check("glitch val", val, 32'h12345672);

        // Two anodes active: nothing moves.
        hold(8'hFC, ~7'h3F, 50);
        check("multihot val", val, 32'h12345672);
        check("multihot digit_valid", {24'h0, digit_valid}, 32'hFF);
        check("multihot decode_err", {31'h0, decode_err}, 32'h0);

        // Unrecognised pattern on digit 4.
        do_reset();
        hold(8'hEF, ~7'h49, 20);
        check("badpat decode_err", {31'h0, decode_err}, 32'h1);
        check("badpat val", val, 32'h0);
        check("badpat digit_valid", {24'h0, digit_valid}, 32'h0);
`ifdef SEVEN_SEGMENT_CAPTURE_ERRCNT_EN
        check("badpat err_count", {24'h0, err_count}, 32'h1);
`endif
        base = fd_pulses;
        scan(32'h12345678, 20, 8'h10);
        check("badpat no frame", base, fd_pulses);
        check("badpat partial dv", {24'h0, digit_valid}, 32'hEF);
        scan(32'h12345678, 20, 8'hEF);
        check("badpat then frame", base + 1, fd_pulses);
        check("badpat sticky", {31'h0, decode_err}, 32'h1);

        // Reset in the middle of a stable digit-3 interval.
        hold(8'hF7, ~seg_of(5), 4);
        do_reset();
        check("midrst val", val, 32'h0);
        check("midrst digit_valid", {24'h0, digit_valid}, 32'h0);
        check("midrst decode_err", {31'h0, decode_err}, 32'h0);
        lat = 0;
        while (lat < 50 && digit_valid[3] !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        check("midrst latency", lat, 2 + STABLE + 1);
        check("midrst digit", val, 32'h00005000);

        // Two passes, digit 2 rewritten in the second.
        do_reset();
        base = fd_pulses;
        scan(32'h12345678, 20, 8'h00);
        scan(32'h12345A78, 20, 8'h00);
        check("twopass frames", base + 2, fd_pulses);
        check("twopass val", val, 32'h12345A78);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
